// File: rtl/cache_controller_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// default geometry and the controller FSM state encoding.
package cache_controller_pkg;

  localparam int INDEX_BITS_DEF = 6;
  localparam int TAG_BITS_DEF   = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

endpackage

// File: rtl/cache_controller_if.sv
// Bus bundle around the cache controller: the pipeline request side
// (addr/wdata/enables -> rdata/ready) and the SRAM controller side.
//
// Handshake: the requester raises mem_r_en or mem_w_en and holds addr, wdata
// and the enables stable for as long as ready is low. The request completes
// in the cycle where ready is high while an enable is set. On the SRAM side
// the controller holds sram_r_en/sram_w_en (with sram_addr/sram_wdata) until
// the cycle in which sram_ready is high; sram_rdata is valid in that cycle.
interface cache_controller_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] rdata;
  logic        ready;

  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  // Environment view: pipeline requester plus SRAM controller.
  modport master (
    output addr, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
    input  rdata, ready, sram_addr, sram_wdata, sram_r_en, sram_w_en
  );

  // Cache controller view.
  modport slave (
    input  addr, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
    output rdata, ready, sram_addr, sram_wdata, sram_r_en, sram_w_en
  );

endinterface

// File: rtl/cache_controller_cache_array.sv
// Line storage for the direct-mapped cache: valid bits (reset), tags and
// one-word data (not reset). One synchronous write port, asynchronous read.
module cache_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  // Valid bits clear on reset; any write makes the line valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage, no reset needed since valid gates their use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache in front of an SRAM
// controller. Requests are sampled live from the bus (the requester holds
// them while ready is low), so there is no internal request register.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_BITS   = TAG_BITS_DEF
) (
  input  logic   clk,
  input  logic   rst,
  cache_controller_if.slave bus,
  output state_t fsm_state
);

  state_t state_q, state_d;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [31:0]           line_data;
  logic                  hit;
  logic                  load_req;

  logic                  arr_we;
  logic [31:0]           arr_wdata;

  logic [31:0]           rdata_c;
  logic                  ready_c;
  logic                  sram_r_en_c;
  logic                  sram_w_en_c;

  // Byte-offset bits and bits above the tag take no part in lookup; tags
  // therefore alias for addresses that differ only above the tag field.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:2+INDEX_BITS+TAG_BITS], bus.addr[1:0]};

  assign req_idx  = bus.addr[2 +: INDEX_BITS];
  assign req_tag  = bus.addr[2+INDEX_BITS +: TAG_BITS];
  assign hit      = line_valid && (line_tag == req_tag);
  // A simultaneous read and write is handled as a write.
  assign load_req = bus.mem_r_en && !bus.mem_w_en;

  // Fill data comes from SRAM on a read miss, otherwise from the store.
  assign arr_wdata = (state_q == RD_MISS) ? bus.sram_rdata : bus.wdata;

  cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (req_idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .we       (arr_we),
    .wr_idx   (req_idx),
    .wr_tag   (req_tag),
    .wr_data  (arr_wdata)
  );

  // FSM state register; reset abandons any outstanding SRAM access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake outputs and cache write enable.
  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b1;
    rdata_c     = 32'h0;
    sram_r_en_c = 1'b0;
    sram_w_en_c = 1'b0;
    arr_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_w_en) begin
          ready_c = 1'b0;
          state_d = WR_THRU;
          arr_we  = hit;          // update on hit, never allocate
        end else if (bus.mem_r_en) begin
          if (hit) begin
            rdata_c = line_data;
          end else begin
            ready_c = 1'b0;
            state_d = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        sram_r_en_c = 1'b1;
        if (bus.sram_ready) begin
          state_d = IDLE;
          // A read that was dropped meanwhile returns nothing and fills nothing.
          if (load_req) begin
            rdata_c = bus.sram_rdata;
            arr_we  = 1'b1;
          end
        end else begin
          ready_c = 1'b0;
        end
      end
      WR_THRU: begin
        sram_w_en_c = 1'b1;
        ready_c     = bus.sram_ready;
        if (bus.sram_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Reset takes effect on the outputs immediately, not at the next edge.
    if (rst) begin
      ready_c     = 1'b1;
      rdata_c     = 32'h0;
      sram_r_en_c = 1'b0;
      sram_w_en_c = 1'b0;
      arr_we      = 1'b0;
    end
  end

  assign bus.rdata      = rdata_c;
  assign bus.ready      = ready_c;
  assign bus.sram_r_en  = sram_r_en_c;
  assign bus.sram_w_en  = sram_w_en_c;
  assign bus.sram_addr  = bus.addr;
  assign bus.sram_wdata = bus.wdata;
  assign fsm_state      = state_q;

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter INDEX_BITS, 6, line-index width (2^INDEX_BITS direct-mapped one-word lines).
REQ-002 Parameter TAG_BITS, 10, tag width; tag = addr[2+INDEX_BITS+TAG_BITS-1 : 2+INDEX_BITS].
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 addr  in  32  byte address from MEM stage ALU result; bits [1:0] ignored.
REQ-007 wdata  in  32  store data (Val_Rm).
REQ-008 mem_r_en  in  1  load request.
REQ-009 mem_w_en  in  1  store request.
REQ-010 rdata  out  32  load data to writeback.
REQ-011 ready  out  1  high = current request complete; low = pipeline must freeze.
REQ-012 sram_addr  out  32  address to SRAM controller.
REQ-013 sram_wdata  out  32  store data to SRAM controller.
REQ-014 sram_r_en  out  1  SRAM read request, held until sram_ready.
REQ-015 sram_w_en  out  1  SRAM write request, held until sram_ready.
REQ-016 sram_rdata  in  32  SRAM read data, valid when sram_ready high.
REQ-017 sram_ready  in  1  SRAM controller completion pulse/level.

Function
REQ-018 Organisation SHALL be direct-mapped, write-through, no-write-allocate; per line: valid bit, tag, 32-bit data.
REQ-019 FSM states SHALL be IDLE, RD_MISS, WR_THRU.
REQ-020 IDLE, no request: ready=1, sram_r_en=0, sram_w_en=0.
REQ-021 IDLE, mem_r_en and hit (valid && tag match): ready=1 same cycle, rdata=line data combinationally, state stays IDLE, no SRAM access.
REQ-022 IDLE, mem_r_en and miss: ready=0 same cycle, go RD_MISS.
REQ-023 RD_MISS: sram_r_en=1, sram_addr=addr; on sram_ready=1 ready=1, rdata=sram_rdata that cycle, line written (valid=1, tag, data) at clock edge, go IDLE.
REQ-024 IDLE, mem_w_en: ready=0 same cycle, go WR_THRU; on hit line data updated to wdata at that edge; on miss cache unchanged.
REQ-025 WR_THRU: sram_w_en=1, sram_addr=addr, sram_wdata=wdata; on sram_ready=1 ready=1, go IDLE.
REQ-026 mem_r_en and mem_w_en both high SHALL be treated as a write.
REQ-027 Requester holds addr/wdata/enables stable while ready=0; controller samples them live, no internal request latch.
REQ-028 Request dropped while in RD_MISS/WR_THRU: SRAM access SHALL still complete, then IDLE; no line written for dropped read.
REQ-029 sram_ready while IDLE SHALL be ignored.
REQ-030 Tag compare SHALL use full TAG_BITS; addresses differing only above the tag field alias (no wrap detection).
REQ-031 rdata SHALL be 0 whenever ready=0 or no load pending.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, all valid bits 0, sram_r_en=0, sram_w_en=0, rdata=0, ready=1; data/tag arrays need not reset.
REQ-033 Reset mid RD_MISS/WR_THRU SHALL abandon the access; first post-reset read misses.

Structure
REQ-034 State encoding and default INDEX_BITS/TAG_BITS SHALL live in the shared package.
REQ-035 One sub-module cache_array (valid/tag/data storage, one write port, async read) SHALL be instantiated; FSM stays in cache_controller.

Verification
REQ-036 Read 0x400 cold, sram_ready after 4 cycles with 0xDEADBEEF -> ready low 4 cycles, rdata=0xDEADBEEF; second read 0x400 -> ready=1 same cycle, no sram_r_en.
REQ-037 Write 0x400 data 0x12345678 after fill -> sram_w_en held until sram_ready; subsequent read 0x400 hits returning 0x12345678.
REQ-038 Write miss 0x800 then read 0x800 -> read misses (no allocate).
REQ-039 Fill 0x400 then read 0x400+(1<<8) (same index, new tag) -> miss, line replaced; reread 0x400 misses.
REQ-040 rst asserted during RD_MISS -> sram_r_en drops same cycle, ready=1; read 0x400 after release misses.
REQ-041 mem_r_en and mem_w_en both high -> WR_THRU, sram_w_en=1, sram_r_en=0.
